// File: rtl/text_buf_ctrl.sv
// Write-side controller for the 70x30 character buffer: turns key codes into cell writes,
// cursor moves and scrolls, and blanks the screen after reset or clr.
module text_buf_ctrl #(
   parameter int         COLS  = 70,
   parameter int         ROWS  = 30,
   parameter logic [7:0] BLANK = 8'h20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [7:0]  key_ascii,
   input  logic        clr,
   output logic        ready,
   output logic        overrun,
   output logic        wr_en,
   output logic [11:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [11:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic [4:0]  cur_row,
   output logic [6:0]  cur_col
);
   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   typedef enum logic [1:0] {CLEAR, IDLE, SCROLL, SCR_CLR} state_t;

   state_t      state_q, state_d;
   logic [4:0]  row_q, row_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  pos_row_q, pos_row_d;
   logic [6:0]  pos_col_q, pos_col_d;
   logic        drain_q, drain_d;
   logic        scr_vld_p1_q, scr_vld_p1_d;
   logic        wr_en_q, wr_en_d;
   logic [11:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        overrun_q, overrun_d;
   logic        accept;
   logic        line_feed;
   logic        pos_last_col;

   function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
      return {r, c};
   endfunction

   always_comb begin
      accept       = key_valid && (state_q == IDLE) && !clr;
      pos_last_col = (pos_col_q == LAST_COL);
      line_feed    = 1'b0;
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      pos_row_d    = pos_row_q;
      pos_col_d    = pos_col_q;
      drain_d      = drain_q;
      scr_vld_p1_d = 1'b0;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      overrun_d    = key_valid && !accept;

      if (clr) begin
         state_d   = CLEAR;
         row_d     = '0;
         col_d     = '0;
         pos_row_d = '0;
         pos_col_d = '0;
         drain_d   = 1'b0;
      end else begin
         case (state_q)
            // CLEAR sweeps the whole screen from (0,0); SCR_CLR enters at (ROWS-1,0)
            CLEAR, SCR_CLR: begin
               wr_en_d   = 1'b1;
               wr_addr_d = cell_addr(pos_row_q, pos_col_q);
               wr_data_d = BLANK;
               if (pos_last_col) begin
                  pos_col_d = '0;
                  if (pos_row_q == LAST_ROW) state_d = IDLE;
                  else pos_row_d = pos_row_q + 5'd1;
               end else begin
                  pos_col_d = pos_col_q + 7'd1;
               end
            end
            SCROLL: begin
               if (drain_q) begin
                  state_d   = SCR_CLR;
                  drain_d   = 1'b0;
                  pos_row_d = LAST_ROW;
                  pos_col_d = '0;
               end else begin
                  // read of the current source lands next cycle, written one row up
                  scr_vld_p1_d = 1'b1;
                  wr_en_d      = 1'b1;
                  wr_addr_d    = cell_addr(pos_row_q - 5'd1, pos_col_q);
                  if (pos_last_col) begin
                     pos_col_d = '0;
                     if (pos_row_q == LAST_ROW) drain_d = 1'b1;
                     else pos_row_d = pos_row_q + 5'd1;
                  end else begin
                     pos_col_d = pos_col_q + 7'd1;
                  end
               end
            end
            default: begin
               if (accept) begin
                  if (key_ascii >= 8'h20 && key_ascii <= 8'h7E) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = cell_addr(row_q, col_q);
                     wr_data_d = key_ascii;
                     if (col_q == LAST_COL) line_feed = 1'b1;
                     else col_d = col_q + 7'd1;
                  end else if (key_ascii == 8'h0A || key_ascii == 8'h0D) begin
                     line_feed = 1'b1;
                  end else if (key_ascii == 8'h08) begin
                     if (col_q != 7'd0) begin
                        col_d     = col_q - 7'd1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr(row_q, col_q - 7'd1);
                        wr_data_d = BLANK;
                     end else if (row_q != 5'd0) begin
                        row_d     = row_q - 5'd1;
                        col_d     = LAST_COL;
                        wr_en_d   = 1'b1;
                        wr_addr_d = cell_addr(row_q - 5'd1, LAST_COL);
                        wr_data_d = BLANK;
                     end
                  end
                  if (line_feed) begin
                     col_d = '0;
                     if (row_q == LAST_ROW) begin
                        state_d   = SCROLL;
                        pos_row_d = 5'd1;
                        pos_col_d = '0;
                        drain_d   = 1'b0;
                     end else begin
                        row_d = row_q + 5'd1;
                     end
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= CLEAR;
         row_q        <= '0;
         col_q        <= '0;
         pos_row_q    <= '0;
         pos_col_q    <= '0;
         drain_q      <= 1'b0;
         scr_vld_p1_q <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= BLANK;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         pos_row_q    <= pos_row_d;
         pos_col_q    <= pos_col_d;
         drain_q      <= drain_d;
         scr_vld_p1_q <= scr_vld_p1_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         overrun_q    <= overrun_d;
      end
   end

   assign ready   = (state_q == IDLE);
   assign overrun = overrun_q;
   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = scr_vld_p1_q ? rd_data : wr_data_q;
   assign rd_addr = cell_addr(pos_row_q, pos_col_q);
   assign cur_row = row_q;
   assign cur_col = col_q;

endmodule
